instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Encodes ARM-style data-processing, load/store and branch requests into 32-bit words.
// DP immediates are searched one even rotation per cycle for an imm8/rot form.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [3:0]  req_cond,
  input  logic [3:0]  req_cmd,
  input  logic        req_s,
  input  logic        req_l,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [3:0]  req_rm,
  input  logic [3:0]  req_rs,
  input  logic [1:0]  req_sh,
  input  logic [4:0]  req_shamt,
  input  logic        req_regshift,
  input  logic [31:0] req_imm,
  input  logic [23:0] req_boff,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        s;
    logic        l;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rs;
    logic [1:0]  sh;
    logic [4:0]  shamt;
    logic        regshift;
    logic [31:0] imm;
    logic [23:0] boff;
  } req_t;

  typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  r, r_nxt;
  logic [7:0]  imm8_q, imm8_nxt;
  logic        fail_q, fail_nxt;
  req_t        req_in, req_q;
  logic        accept;
  logic [63:0] rot_wide;
  logic [31:0] rot_word;
  logic        s_eff;
  logic [11:0] src2;
  logic [31:0] word;
  logic        word_err;

  assign req_in = {req_kind, req_cond, req_cmd, req_s, req_l, req_rn, req_rd, req_rm,
                   req_rs, req_sh, req_shamt, req_regshift, req_imm, req_boff};

  assign accept   = (state == IDLE) && req_valid;
  // Rotate-left by 2r: the upper half of the doubled word shifted left.
  assign rot_wide = {req_q.imm, req_q.imm} << {r, 1'b0};
  assign rot_word = rot_wide[63:32];

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    imm8_nxt  = imm8_q;
    fail_nxt  = fail_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          fail_nxt = 1'b0;
          r_nxt    = '0;
          state_nxt = (req_kind == 2'b00) ? SEARCH : OUT;
        end
      end
      SEARCH: begin
        if (rot_word[31:8] == 24'h0) begin
          imm8_nxt  = rot_word[7:0];
          state_nxt = OUT;
        end else if (r == 4'd15) begin
          fail_nxt  = 1'b1;
          state_nxt = OUT;
        end else begin
          r_nxt = r + 4'd1;
        end
      end
      OUT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      r      <= '0;
      imm8_q <= '0;
      fail_q <= 1'b0;
      req_q  <= '0;
    end else begin
      state  <= state_nxt;
      r      <= r_nxt;
      imm8_q <= imm8_nxt;
      fail_q <= fail_nxt;
      if (accept) req_q <= req_in;
    end
  end

  // Output word is built from the held request, so it stays stable through OUT.
  always_comb begin
    s_eff    = (req_q.cmd[3:2] == 2'b10) ? 1'b1 : req_q.s;
    src2     = req_q.regshift ? {req_q.rs, 1'b0, req_q.sh, 1'b1, req_q.rm}
                              : {req_q.shamt, req_q.sh, 1'b0, req_q.rm};
    word     = '0;
    word_err = 1'b0;
    case (req_q.kind)
      2'b00: begin
        word_err = fail_q;
        word     = {req_q.cond, 2'b00, 1'b1, req_q.cmd, s_eff, req_q.rn, req_q.rd, r, imm8_q};
      end
      2'b01: word = {req_q.cond, 2'b00, 1'b0, req_q.cmd, s_eff, req_q.rn, req_q.rd, src2};
      2'b10: begin
        word_err = (req_q.imm[31:12] != 20'h0);
        word     = {req_q.cond, 2'b01, 5'b01100, req_q.l, req_q.rn, req_q.rd, req_q.imm[11:0]};
      end
      default: word = {req_q.cond, 2'b10, 2'b10, req_q.boff};
    endcase
  end

  assign req_ready = (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_err   = out_valid & word_err;
  assign out_instr = (out_valid && !word_err) ? word : 32'h0;

endmodule
